// File: rtl/mem_access_unit.sv
// CPU-side initiator for the 16-bit data memory: one load/store/push/pop at a time,
// owns the stack pointer and flags stack overflow/underflow.
module mem_access_unit #(
  parameter logic [15:0] STACK_TOP   = 16'hFFFF,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [8:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        err_overflow,
  output logic        err_underflow,
  input  logic        clr_err,
  output logic [15:0] sp_out,
  output logic        mem_store,
  output logic        mem_load,
  output logic        mem_push,
  output logic        mem_pop,
  output logic [8:0]  mem_address,
  output logic [15:0] mem_sp,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out
);

  localparam logic [1:0] OP_STORE = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_READ  = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] sp_r;
  logic [1:0]  op_r;
  logic [8:0]  addr_r;
  logic [15:0] wdata_r;
  logic        ovf_r;
  logic        unf_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_data_r;
  logic        rsp_err_r;
  logic        err_overflow_r;
  logic        err_underflow_r;
  logic        accept_s;
  logic        err_s;
  logic        issue_s;
  logic        rd_op_s;

  assign req_ready = (state_r == ST_IDLE);
  assign accept_s  = req_valid && req_ready;
  assign err_s     = ovf_r || unf_r;
  assign rd_op_s   = (op_r == OP_LOAD) || (op_r == OP_POP);
  // A rejected request never reaches the memory.
  assign issue_s   = (state_r == ST_ISSUE) && !err_s;

  assign mem_store   = issue_s && (op_r == OP_STORE);
  assign mem_load    = issue_s && (op_r == OP_LOAD);
  assign mem_push    = issue_s && (op_r == OP_PUSH);
  assign mem_pop     = issue_s && (op_r == OP_POP);
  assign mem_sp      = (op_r == OP_POP) ? (sp_r + 16'd1) : sp_r;
  assign mem_address = addr_r;
  assign mem_data_in = wdata_r;

  assign sp_out        = sp_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_data      = rsp_data_r;
  assign rsp_err       = rsp_err_r;
  assign err_overflow  = err_overflow_r;
  assign err_underflow = err_underflow_r;

  // Next-state decode for the request sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!err_s && rd_op_s) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, request latches, stack pointer, responses and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      sp_r            <= STACK_TOP;
      op_r            <= 2'b00;
      addr_r          <= 9'd0;
      wdata_r         <= 16'd0;
      ovf_r           <= 1'b0;
      unf_r           <= 1'b0;
      rsp_valid_r     <= 1'b0;
      rsp_data_r      <= 16'd0;
      rsp_err_r       <= 1'b0;
      err_overflow_r  <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      rsp_valid_r <= 1'b0;
      if (accept_s) begin
        op_r    <= req_op;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        ovf_r   <= (req_op == OP_PUSH) && (sp_r == STACK_LIMIT);
        unf_r   <= (req_op == OP_POP) && (sp_r == STACK_TOP);
      end
      if (state_r == ST_ISSUE) begin
        if (!err_s && (op_r == OP_PUSH)) begin
          sp_r <= sp_r - 16'd1;
        end else if (!err_s && (op_r == OP_POP)) begin
          sp_r <= sp_r + 16'd1;
        end
        if (err_s || !rd_op_s) begin
          rsp_valid_r <= 1'b1;
          rsp_data_r  <= 16'd0;
          rsp_err_r   <= err_s;
        end
      end
      if (state_r == ST_READ) begin
        rsp_valid_r <= 1'b1;
        rsp_data_r  <= mem_data_out;
        rsp_err_r   <= 1'b0;
      end
      // A new error on the same edge as clr_err keeps the flag set.
      err_overflow_r  <= (err_overflow_r && !clr_err) || ((state_r == ST_ISSUE) && ovf_r);
      err_underflow_r <= (err_underflow_r && !clr_err) || ((state_r == ST_ISSUE) && unf_r);
    end
  end

endmodule
